fir_mac_accum: RTL and testbench



---
 rtl/fir_mac_accum.sv | 129 ++++++++++++
 tb/tb_fir_mac_accum.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_accum.sv
// fir_mac_accum
//   Tap accumulator that sits after the registered signed multiplier in the
//   FIR datapath. It sums NUM_TAPS valid products, then rounds (half up),
//   arithmetically shifts by SHIFT and saturates to OUT_WIDTH. The result is
//   held in a one-entry valid/ready output register.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   clear_i           frame abort: drop the partial sum, tap counter -> 0
//   product_i         signed product, PROD_WIDTH bits
//   product_valid_i   product_i valid; always accepted (no backpressure)
//   tap_index_o       index of the next product to be accepted
//   result_o          signed rounded/saturated sum, OUT_WIDTH bits
//   result_valid_o    result_o valid, held until result_ready_i
//   result_ready_i    downstream accept
//   sat_o             result_o was clipped (qualified by result_valid_o)
//   overrun_o         one-cycle pulse: an unaccepted result was overwritten
module fir_mac_accum #(
  parameter int PROD_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int NUM_TAPS   = 16
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              clear_i,
  input  logic [PROD_WIDTH-1:0]                             product_i,
  input  logic                                              product_valid_i,
  output logic [((NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1)-1:0] tap_index_o,
  output logic [OUT_WIDTH-1:0]                              result_o,
  output logic                                              result_valid_o,
  input  logic                                              result_ready_i,
  output logic                                              sat_o,
  output logic                                              overrun_o
);

  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  // 2^(SHIFT-1), or 0 when SHIFT==0 (the 1 is shifted back out).
  localparam logic signed [ACC_WIDTH:0] RND = ((ACC_WIDTH + 1)'(1) << SHIFT) >> 1;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [TAP_W-1:0]            cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]        res_q, res_d;
  logic                        sat_q, sat_d;
  logic                        vld_q, vld_d;
  logic                        ovr_q, ovr_d;

  logic signed [PROD_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  total;
  logic signed [ACC_WIDTH:0]    rnd;
  logic signed [ACC_WIDTH:0]    q;
  logic [ACC_WIDTH-OUT_WIDTH+1:0] q_hi;
  logic                         accept, done, xfer, in_range;
  logic [OUT_WIDTH-1:0]         res_new;

  assign prod_s   = product_i;
  assign prod_ext = ACC_WIDTH'(prod_s);

  // Tap 0 loads rather than adds, so no separate clear of acc is needed
  // between frames.
  assign total = ((cnt_q == '0) ? '0 : acc_q) + prod_ext;

  // One extra bit so the rounding constant cannot wrap a near-max total.
  assign rnd = {total[ACC_WIDTH-1], total} + RND;
  assign q   = rnd >>> SHIFT;

  // q fits OUT_WIDTH iff all bits from the OUT_WIDTH sign bit upward agree.
  assign q_hi     = q[ACC_WIDTH:OUT_WIDTH-1];
  assign in_range = (&q_hi) | ~(|q_hi);
  assign res_new  = in_range ? q[OUT_WIDTH-1:0]
                  : (q[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}});

  assign accept = product_valid_i & ~clear_i;
  assign done   = accept & (cnt_q == LAST_TAP);
  assign xfer   = vld_q & result_ready_i;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    sat_d = sat_q;
    vld_d = vld_q;
    ovr_d = 1'b0;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (product_valid_i) begin
      acc_d = total;
      cnt_d = (cnt_q == LAST_TAP) ? '0 : cnt_q + TAP_W'(1);
    end
    if (done) begin
      res_d = res_new;
      sat_d = ~in_range;
      vld_d = 1'b1;
      ovr_d = vld_q & ~result_ready_i;
    end else if (xfer) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      sat_q <= 1'b0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      sat_q <= sat_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
    end
  end

  assign tap_index_o    = cnt_q;
  assign result_o       = res_q;
  assign result_valid_o = vld_q;
  assign sat_o          = sat_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_fir_mac_accum.sv
// Bench for fir_mac_accum: a 4-tap instance exercised with directed and
// random frames, plus a 1-tap instance fed in parallel.
module tb_fir_mac_accum;
  localparam int PW = 32;
  localparam int AW = 40;
  localparam int OW = 16;
  localparam int SH = 15;
  localparam int NT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clr, pv, rdy;
  logic [PW-1:0] prod;
  logic [1:0]    tap;
  logic [OW-1:0] res;
  logic          rv, sat, ovr;

  logic          pv1;
  logic [PW-1:0] prod1;
  logic [0:0]    tap1;
  logic [OW-1:0] res1;
  logic          rv1, sat1, ovr1;

  fir_mac_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH), .NUM_TAPS(NT)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .product_i(prod), .product_valid_i(pv),
    .tap_index_o(tap), .result_o(res), .result_valid_o(rv), .result_ready_i(rdy),
    .sat_o(sat), .overrun_o(ovr));

  fir_mac_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH), .NUM_TAPS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(1'b0), .product_i(prod1), .product_valid_i(pv1),
    .tap_index_o(tap1), .result_o(res1), .result_valid_o(rv1), .result_ready_i(1'b1),
    .sat_o(sat1), .overrun_o(ovr1));

  int n_vec = 0;
  int n_err = 0;

  // reference state: products of the open frame, plus the output register view
  longint frame[$];
  bit     m_vld, m_sat, m_ovr;
  longint m_res;
  bit     m1_vld, m1_sat;
  longint m1_res;

  // Round half up, floor-shift, clamp to the signed output range.
  function automatic void finalize(input longint total, output longint r, output bit s);
    longint q, hi, lo;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    q  = (SH == 0) ? total : ((total + (longint'(1) << (SH - 1))) >>> SH);
    s  = (q > hi) || (q < lo);
    r  = (q > hi) ? hi : ((q < lo) ? lo : q);
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input longint p, input bit c, input bit r, input bit rd,
                      input bit v1 = 1'b0, input longint p1 = 0);
    longint sum;
    bit done;
    pv = v; prod = p[PW-1:0]; clr = c; rst = r; rdy = rd;
    pv1 = v1; prod1 = p1[PW-1:0];
    @(posedge clk);
    done = 1'b0;
    if (r) begin
      frame.delete();
      m_vld = 0; m_sat = 0; m_ovr = 0; m_res = 0;
      m1_vld = 0; m1_sat = 0; m1_res = 0;
    end else begin
      if (c) frame.delete();
      else if (v) begin
        frame.push_back(p);
        done = (frame.size() == NT);
      end
      m_ovr = done && m_vld && !rd;
      if (done) begin
        sum = 0;
        foreach (frame[i]) sum += frame[i];
        frame.delete();
        finalize(sum, m_res, m_sat);
        m_vld = 1;
      end else if (m_vld && rd) m_vld = 0;
      m1_vld = v1;
      if (v1) finalize(p1, m1_res, m1_sat);
    end
    #1;
    chk("tap_index", tap, frame.size());
    chk("result_valid", rv, m_vld);
    chk("result", longint'($signed(res)), m_res);
    chk("sat", sat, m_sat);
    chk("overrun", ovr, m_ovr);
    chk("t1_valid", rv1, m1_vld);
    chk("t1_result", longint'($signed(res1)), m1_res);
    chk("t1_sat", sat1, m1_sat);
    chk("t1_overrun", ovr1, 1'b0);
    chk("t1_tap", tap1, 0);
  endtask

  task automatic frame4(input longint p0, input longint p1, input longint p2, input longint p3,
                        input bit rd);
    step(1, p0, 0, 0, rd);
    step(1, p1, 0, 0, rd);
    step(1, p2, 0, 0, rd);
    step(1, p3, 0, 0, rd);
  endtask

  initial begin
    if (AW < PW + $clog2(NT)) begin
      $display("FAIL param_acc_width ACC_WIDTH=%0d required>=%0d", AW, PW + $clog2(NT));
      $fatal(1, "accumulator width constraint violated");
    end
    assert (AW >= PW + $clog2(NT));

    // reset state
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);

    // basic frame: result 4, valid for one cycle
    frame4(32768, 32768, 32768, 32768, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // rounding boundaries
    frame4(16384, 0, 0, 0, 1);
    frame4(16383, 0, 0, 0, 1);
    frame4(-16384, 0, 0, 0, 1);
    frame4(-16385, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // saturation both ways
    frame4(32'h3FFF0000, 32'h3FFF0000, 32'h3FFF0000, 32'h3FFF0000, 1);
    frame4(-32'sh40000000, -32'sh40000000, -32'sh40000000, -32'sh40000000, 1);
    step(0, 0, 0, 0, 1);

    // overrun: two frames unaccepted, then ready on the next completion
    frame4(32768, 32768, 32768, 32768, 0);
    step(0, 0, 0, 0, 0);
    frame4(65536, 65536, 65536, 65536, 0);
    step(0, 0, 0, 0, 0);
    step(1, 32768, 0, 0, 0);
    step(1, 32768, 0, 0, 0);
    step(1, 32768, 0, 0, 0);
    step(1, 32768, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // abort with clear, then with reset
    step(1, 32768, 0, 0, 1);
    step(1, 32768, 0, 0, 1);
    step(1, 32768, 1, 0, 1);
    frame4(32768, 32768, 32768, 32768, 1);
    step(1, 32768, 0, 0, 1);
    step(1, 32768, 0, 0, 1);
    step(1, 32768, 0, 1, 1);
    frame4(32768, 32768, 32768, 32768, 1);

    // gapped input
    step(1, 32768, 0, 0, 1);
    step(0, 99999, 0, 0, 1);
    step(0, -5, 0, 0, 1);
    step(1, 32768, 0, 0, 1);
    step(0, 7, 0, 0, 1);
    step(1, 32768, 0, 0, 1);
    step(1, 32768, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // 1-tap instance, directed
    step(0, 0, 0, 0, 1, 1, 32768);
    step(0, 0, 0, 0, 1, 1, -16385);
    step(0, 0, 0, 0, 1, 1, 32'h7FFFFFFF);
    step(0, 0, 0, 0, 1, 0, 0);

    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      bit rv_in, rc, rr, rv1_in;
      longint rp, rp1;
      rv_in  = ($urandom_range(3) != 0);
      rc     = ($urandom_range(29) == 0);
      rr     = ($urandom_range(2) != 0);
      rv1_in = $urandom_range(1);
      rp  = longint'($signed($urandom()));
      rp1 = longint'($signed($urandom()));
      if ($urandom_range(1) == 0) rp = rp >>> $urandom_range(20);
      if ($urandom_range(1) == 0) rp1 = rp1 >>> $urandom_range(20);
      step(rv_in, rp, rc, 0, rr, rv1_in, rp1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
